// File: rtl/microseq.sv
// Am2910-style microprogram next-address sequencer: uPC, loop counter R and a
// DEPTH-entry LIFO for subroutine returns and loop starts.
module microseq #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       I,
    input  logic [WIDTH-1:0] D,
    input  logic             CT,
    input  logic             nCCEN,
    input  logic             CI,
    input  logic             nRLD,
    output logic [WIDTH-1:0] Y,
    output logic             nFULL,
    output logic             nPL,
    output logic             nMAP,
    output logic             nVECT
);
    localparam int SPW = $clog2(DEPTH + 1);

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,  OP_CJS  = 4'd1,  OP_JMAP = 4'd2,  OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,  OP_JSRP = 4'd5,  OP_CJV  = 4'd6,  OP_JRP  = 4'd7,
        OP_RFCT = 4'd8,  OP_RPCT = 4'd9,  OP_CRTN = 4'd10, OP_CJPP = 4'd11,
        OP_LDCT = 4'd12, OP_LOOP = 4'd13, OP_CONT = 4'd14, OP_TWB  = 4'd15
    } op_e;

    logic [WIDTH-1:0] r_upc;
    logic [WIDTH-1:0] r_cnt;
    logic [SPW-1:0]   r_sp;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic             w_pass;
    logic             w_rnz;
    logic             w_full;
    logic [WIDTH-1:0] w_top;
    logic [SPW-1:0]   w_wr_idx;
    logic [WIDTH-1:0] w_y;
    logic             w_push;
    logic             w_pop;
    logic             w_clr;
    logic             w_rload;
    logic             w_rdec;

    assign w_pass = nCCEN | CT;
    assign w_rnz  = (r_cnt != '0);
    assign w_full = (r_sp == SPW'(DEPTH));

    // Entry k holds stack level k+1; an empty stack reads as zero.
    always_comb begin
        w_top = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_sp == SPW'(k + 1)) begin
                w_top = r_stack[k];
            end
        end
    end

    // When full, a push overwrites the top entry instead of growing.
    assign w_wr_idx = w_full ? SPW'(DEPTH - 1) : r_sp;

    always_comb begin
        w_y     = r_upc;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_clr   = 1'b0;
        w_rload = 1'b0;
        w_rdec  = 1'b0;
        case (op_e'(I))
            OP_JZ: begin
                w_y   = '0;
                w_clr = 1'b1;
            end
            OP_CJS: begin
                if (w_pass) begin
                    w_y    = D;
                    w_push = 1'b1;
                end
            end
            OP_JMAP: w_y = D;
            OP_CJP:  w_y = w_pass ? D : r_upc;
            OP_PUSH: begin
                w_push  = 1'b1;
                w_rload = w_pass;
            end
            OP_JSRP: begin
                w_push = 1'b1;
                w_y    = w_pass ? D : r_cnt;
            end
            OP_CJV: w_y = w_pass ? D : r_upc;
            OP_JRP: w_y = w_pass ? D : r_cnt;
            OP_RFCT: begin
                if (w_rnz) begin
                    w_y    = w_top;
                    w_rdec = 1'b1;
                end else begin
                    w_pop = 1'b1;
                end
            end
            OP_RPCT: begin
                if (w_rnz) begin
                    w_y    = D;
                    w_rdec = 1'b1;
                end
            end
            OP_CRTN: begin
                if (w_pass) begin
                    w_y   = w_top;
                    w_pop = 1'b1;
                end
            end
            OP_CJPP: begin
                if (w_pass) begin
                    w_y   = D;
                    w_pop = 1'b1;
                end
            end
            OP_LDCT: w_rload = 1'b1;
            OP_LOOP: begin
                if (w_pass) begin
                    w_pop = 1'b1;
                end else begin
                    w_y = w_top;
                end
            end
            OP_CONT: w_y = r_upc;
            OP_TWB: begin
                if (w_rnz && !w_pass) begin
                    w_y    = w_top;
                    w_rdec = 1'b1;
                end else if (!w_rnz && !w_pass) begin
                    w_y   = D;
                    w_pop = 1'b1;
                end else begin
                    w_pop = 1'b1;
                end
            end
            default: w_y = r_upc;
        endcase
    end

    assign Y     = w_y;
    assign nFULL = ~w_full;
    assign nMAP  = (I != 4'd2);
    assign nVECT = (I != 4'd6);
    assign nPL   = (I == 4'd2) || (I == 4'd6);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_upc <= '0;
            r_cnt <= '0;
            r_sp  <= '0;
        end else begin
            r_upc <= w_y + WIDTH'(CI);
            // An external R load wins over both decrement and LDCT/PUSH loads.
            if (!nRLD || w_rload) begin
                r_cnt <= D;
            end else if (w_rdec) begin
                r_cnt <= r_cnt - WIDTH'(1);
            end
            if (w_clr) begin
                r_sp <= '0;
            end else if (w_push && !w_full) begin
                r_sp <= r_sp + SPW'(1);
            end else if (w_pop && (r_sp != '0)) begin
                r_sp <= r_sp - SPW'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_stack[gi] <= '0;
                end else if (w_push && (w_wr_idx == SPW'(gi))) begin
                    r_stack[gi] <= r_upc;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_microseq.sv
// Directed bench for microseq: sequencing, subroutines, loops, stack limits,
// enables, TWB and asynchronous reset, all against hand-computed addresses.
module tb_microseq;
    logic        clk;
    logic        reset;
    logic [3:0]  I;
    logic [11:0] D;
    logic        CT;
    logic        nCCEN;
    logic        CI;
    logic        nRLD;
    logic [11:0] Y;
    logic        nFULL;
    logic        nPL;
    logic        nMAP;
    logic        nVECT;

    int n_tests = 0;
    int n_fail  = 0;

    microseq #(.WIDTH(12), .DEPTH(5)) dut (
        .clk(clk), .reset(reset), .I(I), .D(D), .CT(CT), .nCCEN(nCCEN),
        .CI(CI), .nRLD(nRLD), .Y(Y), .nFULL(nFULL), .nPL(nPL),
        .nMAP(nMAP), .nVECT(nVECT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic drive(input logic [3:0] i, input logic [11:0] d, input logic ct, input logic ncc);
        I = i; D = d; CT = ct; nCCEN = ncc;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] ret_exp [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; I = 4'd14; D = '0; CT = 1'b0; nCCEN = 1'b1; CI = 1'b1; nRLD = 1'b1;
        tick();
        check("reset_y", Y, 0);
        check("reset_nfull", nFULL, 1);
        reset = 1'b0;

        // Plain sequencing
        drive(14, 0, 0, 1);
        check("cont_y0", Y, 0);
        check("cont_npl", nPL, 0);
        check("cont_nmap", nMAP, 1);
        check("cont_nvect", nVECT, 1);
        check("cont_nfull", nFULL, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("cont_seq", Y, k);
        end
        CI = 1'b0;
        tick();
        check("ci0_hold", Y, 3);
        CI = 1'b1;

        // Subroutine call and return
        drive(2, 12'h010, 0, 1); check("jmap_10", Y, 12'h010); tick();
        drive(1, 12'h200, 0, 1); check("cjs_pass", Y, 12'h200); tick();
        drive(14, 0, 0, 1);      check("sub_cont1", Y, 12'h201); tick();
        check("sub_cont2", Y, 12'h202); tick();
        drive(10, 0, 1, 0);      check("crtn_ret", Y, 12'h011); tick();
        drive(10, 0, 1, 0);      check("crtn_empty", Y, 0); tick();
        drive(1, 12'h200, 0, 0); check("cjs_fail", Y, 1); tick();

        // RFCT loop of three iterations
        drive(2, 12'h01F, 0, 1); tick();
        drive(4, 12'h3AA, 0, 0); check("push_y", Y, 12'h020); tick();
        drive(12, 12'd3, 0, 1);  check("ldct_y", Y, 12'h021); tick();
        for (int k = 0; k < 3; k++) begin
            drive(8, 0, 0, 1); check("rfct_loop", Y, 12'h020); tick();
        end
        drive(8, 0, 0, 1);       check("rfct_exit", Y, 12'h021); tick();
        drive(10, 0, 1, 0);      check("rfct_popped", Y, 0); tick();

        // Stack fill, overflow overwrite and unwind
        drive(2, 12'h050, 0, 1); tick();
        for (int k = 0; k < 6; k++) begin
            drive(1, 12'h100 + 12'(k), 1, 0);
            check("fill_y", Y, 12'h100 + k);
            check("fill_nfull", nFULL, (k >= 5) ? 0 : 1);
            tick();
        end
        check("full_nfull", nFULL, 0);
        ret_exp[0] = 12'h105; ret_exp[1] = 12'h103; ret_exp[2] = 12'h102;
        ret_exp[3] = 12'h101; ret_exp[4] = 12'h051;
        for (int k = 0; k < 5; k++) begin
            drive(10, 0, 1, 0); check("unwind_y", Y, ret_exp[k]); tick();
        end
        drive(10, 0, 1, 0);      check("unwind_empty", Y, 0);
        check("unwind_nfull", nFULL, 1); tick();

        // Enables: JMAP and CJV
        drive(2, 12'hABC, 0, 1);
        check("jmap_y", Y, 12'hABC);
        check("jmap_nmap", nMAP, 0);
        check("jmap_npl", nPL, 1);
        check("jmap_nvect", nVECT, 1);
        tick();
        drive(6, 12'h3C0, 0, 0);
        check("cjv_fail_y", Y, 12'hABD);
        check("cjv_nvect", nVECT, 0);
        check("cjv_npl", nPL, 1);
        check("cjv_nmap", nMAP, 1);
        drive(6, 12'h3C0, 1, 0);
        check("cjv_pass_y", Y, 12'h3C0);
        tick();

        // JZ clears the stack
        drive(1, 12'h400, 1, 1); tick();
        drive(0, 12'h777, 1, 1); check("jz_y", Y, 0); tick();
        drive(10, 0, 1, 1);      check("jz_cleared", Y, 0); tick();

        // nRLD overrides a same-cycle decrement
        drive(12, 12'd1, 0, 1);  tick();
        nRLD = 1'b0;
        drive(9, 12'h077, 0, 1); check("rpct_r1", Y, 12'h077); tick();
        nRLD = 1'b1;
        drive(9, 12'h066, 0, 1); check("nrld_override", Y, 12'h066); tick();

        // TWB with R = 2
        drive(2, 12'h300, 0, 1); tick();
        drive(4, 0, 0, 0);       check("twb_push", Y, 12'h301); tick();
        drive(12, 12'd2, 0, 1);  check("twb_ldct", Y, 12'h302); tick();
        drive(15, 12'h7FF, 0, 0); check("twb_fail1", Y, 12'h301); tick();
        drive(15, 12'h7FF, 0, 0); check("twb_fail2", Y, 12'h301); tick();
        drive(15, 12'h7FF, 1, 0); check("twb_pass", Y, 12'h302); tick();
        drive(9, 12'h055, 0, 1); check("twb_r_zero", Y, 12'h303); tick();
        drive(10, 0, 1, 1);      check("twb_popped", Y, 0); tick();
        drive(4, 0, 0, 0);       tick();
        drive(15, 12'h123, 0, 0); check("twb_r0_fail", Y, 12'h123); tick();
        drive(10, 0, 1, 1);      check("twb_r0_pop", Y, 0); tick();

        // Asynchronous reset in the middle of a cycle
        for (int k = 0; k < 5; k++) begin
            drive(4, 0, 0, 0); tick();
        end
        check("pre_reset_full", nFULL, 0);
        drive(12, 12'd7, 0, 1); tick();
        drive(14, 0, 0, 1);
        check("pre_reset_y", Y, 12'h007);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_y", Y, 0);
        check("async_rst_nfull", nFULL, 1);
        drive(9, 12'h055, 0, 1); check("async_rst_r", Y, 0);
        drive(10, 0, 1, 1);      check("async_rst_f", Y, 0);
        tick();
        reset = 1'b0;
        drive(14, 0, 0, 1);      check("post_rst_y0", Y, 0); tick();
        check("post_rst_y1", Y, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
